// File: rtl/score_pkg.sv
// Shared types and constants for the score BCD reader.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE,
        HOLD
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;

    localparam int BCD_DIGITS = 5;
    localparam int CONV_BITS  = 16;

    // Double-dabble correction: +3 on every nibble that is 5 or more.
    function automatic logic [4*BCD_DIGITS-1:0] dabble_adj(
        input logic [4*BCD_DIGITS-1:0] b
    );
        logic [4*BCD_DIGITS-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Decimal digit to active-low 7-segment pattern, bit 0 = segment a.
module seg7_dec
    import score_pkg::*;
(
    input  logic [3:0] digit,
    output logic [0:6] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_ZERO;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0001100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_bcd_reader.sv
// Captures the score on game-over, converts to BCD, tracks high score.
// Optional HEX blinking on a new high score: define SCORE_BLINK_EN.
module score_bcd_reader
    import score_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] score,
    input  logic        collision,
    output logic        busy,
    output logic        done,
    output logic [19:0] final_bcd,
    output logic [15:0] hi_score,
    output logic        new_high,
    output logic        ovf,
    output logic [0:6]  HEX0,
    output logic [0:6]  HEX1,
    output logic [0:6]  HEX2,
    output logic [0:6]  HEX3
);

    state_t      state;
    logic        collision_d;
    logic [15:0] sh;
    logic [15:0] cap;
    logic [19:0] acc;
    logic [3:0]  cnt;
    logic [0:6]  seg0, seg1, seg2, seg3;
    logic [0:6]  hex0_q, hex1_q, hex2_q, hex3_q;

    seg7_dec u_dec0 (.digit(acc[3:0]),   .seg(seg0));
    seg7_dec u_dec1 (.digit(acc[7:4]),   .seg(seg1));
    seg7_dec u_dec2 (.digit(acc[11:8]),  .seg(seg2));
    seg7_dec u_dec3 (.digit(acc[15:12]), .seg(seg3));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            collision_d <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            final_bcd   <= '0;
            hi_score    <= '0;
            new_high    <= 1'b0;
            ovf         <= 1'b0;
            sh          <= '0;
            cap         <= '0;
            acc         <= '0;
            cnt         <= '0;
            hex0_q      <= SEG_ZERO;
            hex1_q      <= SEG_ZERO;
            hex2_q      <= SEG_ZERO;
            hex3_q      <= SEG_ZERO;
        end else begin
            collision_d <= collision;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (collision && !collision_d) begin
                        sh    <= score;
                        cap   <= score;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    {acc, sh} <= {dabble_adj(acc), sh} << 1;
                    cnt       <= cnt + 4'd1;
                    if (cnt == 4'(CONV_BITS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    final_bcd <= acc;
                    ovf       <= (acc[19:16] != 4'd0);
                    if (cap > hi_score) begin
                        hi_score <= cap;
                        new_high <= 1'b1;
                    end else begin
                        new_high <= 1'b0;
                    end
                    hex0_q <= seg0;
                    hex1_q <= seg1;
                    hex2_q <= seg2;
                    hex3_q <= seg3;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= HOLD;
                end
                HOLD: begin
                    if (!collision) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCORE_BLINK_EN
    logic [31:0] blink_cnt;
    logic        phase;

    // Blink phase restarts at each result update.
    always_ff @(posedge clk) begin
        if (!resetn || state == DONE) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_DIV - 1) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end

    assign HEX0 = (new_high && phase) ? SEG_BLANK : hex0_q;
    assign HEX1 = (new_high && phase) ? SEG_BLANK : hex1_q;
    assign HEX2 = (new_high && phase) ? SEG_BLANK : hex2_q;
    assign HEX3 = (new_high && phase) ? SEG_BLANK : hex3_q;
`else
    logic blink_unused;
    assign blink_unused = (BLINK_DIV != 0);

    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
    assign HEX2 = hex2_q;
    assign HEX3 = hex3_q;
`endif

endmodule

// File: tb/tb_score_bcd_reader.sv
// Self-checking bench for score_bcd_reader (default build).
module tb_score_bcd_reader;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] score;
    logic        collision;
    logic        busy;
    logic        done;
    logic [19:0] final_bcd;
    logic [15:0] hi_score;
    logic        new_high;
    logic        ovf;
    logic [0:6]  HEX0, HEX1, HEX2, HEX3;

    int checks = 0;
    int errors = 0;
    int hi_m   = 0;
    int nh_m   = 0;

    score_bcd_reader #(.BLINK_DIV(4)) dut (
        .clk(clk), .resetn(resetn), .score(score), .collision(collision),
        .busy(busy), .done(done), .final_bcd(final_bcd),
        .hi_score(hi_score), .new_high(new_high), .ovf(ovf),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0001100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] hex_exp(input int v);
        logic [27:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[7*i +: 7] = seg_of(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_capture(input int s);
        if (s > hi_m) begin
            hi_m = s;
            nh_m = 1;
        end else begin
            nh_m = 0;
        end
    endtask

    task automatic check_results(input string tag, input int s);
        check({tag, "_bcd"}, 32'(final_bcd), 32'(to_bcd(s)));
        check({tag, "_ovf"}, 32'(ovf), 32'(s > 9999));
        check({tag, "_hi"}, 32'(hi_score), 32'(hi_m));
        check({tag, "_nh"}, 32'(new_high), 32'(nh_m));
        check({tag, "_hex"}, 32'({HEX3, HEX2, HEX1, HEX0}), 32'(hex_exp(s)));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_bcd"}, 32'(final_bcd), 32'd0);
        check({tag, "_hi"}, 32'(hi_score), 32'd0);
        check({tag, "_nh"}, 32'(new_high), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
        check({tag, "_hex"}, 32'({HEX3, HEX2, HEX1, HEX0}), 32'(hex_exp(0)));
    endtask

    // One full capture; the score input is scrambled after the trigger.
    task automatic run(input string tag, input int s);
        int bad;
        score = 16'(s);
        collision = 1'b1;
        tick();
        score = 16'($urandom_range(0, 65535));
        bad = 0;
        if (!(busy === 1'b1 && done === 1'b0)) bad++;
        repeat (16) begin
            tick();
            if (!(busy === 1'b1 && done === 1'b0)) bad++;
        end
        check({tag, "_busywin"}, 32'(bad), 32'd0);
        tick();
        model_capture(s);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy0"}, 32'(busy), 32'd0);
        check_results(tag, s);
        tick();
        check({tag, "_done1"}, 32'(done), 32'd0);
        collision = 1'b0;
        tick();
    endtask

    initial begin
        int pulses;
        int a;
        resetn = 1'b0;
        collision = 1'b0;
        score = '0;
        tick();
        tick();
        check_reset("rst");
        resetn = 1'b1;
        tick();

        run("s1234", 1234);
        run("s50a", 50);
        run("s30", 30);
        run("s50b", 50);
        run("s70", 70);
        run("s9999", 9999);
        run("s10000", 10000);
        run("s65535", 65535);
        run("s0", 0);
        for (int i = 0; i < 8; i++) begin
            run($sformatf("rnd%0d", i), int'($urandom_range(0, 65535)));
        end

        // Reset asserted at edge k+8 during conversion.
        score = 16'd777;
        collision = 1'b1;
        tick();
        score = 16'($urandom_range(0, 65535));
        repeat (7) tick();
        resetn = 1'b0;
        tick();
        hi_m = 0;
        nh_m = 0;
        check_reset("midrst");
        resetn = 1'b1;
        collision = 1'b0;
        pulses = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        check("midrst_nodone", 32'(pulses), 32'd0);
        run("after_rst", 4321);

        // Retrigger during CONV, collision held high through HOLD.
        a = int'($urandom_range(0, 65535));
        score = 16'(a);
        collision = 1'b1;
        tick();
        score = 16'($urandom_range(0, 65535));
        repeat (3) tick();
        collision = 1'b0;
        tick();
        collision = 1'b1;
        pulses = 0;
        repeat (30) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        model_capture(a);
        check("retrig_pulses", 32'(pulses), 32'd1);
        check_results("retrig", a);
        collision = 1'b0;
        tick();
        run("final", 12345);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_bcd_reader.md
Name: score_bcd_reader

Overview:
- Reader at the far end of the score counter's 16-bit binary output.
- On game-over (rising edge of collision), captures the binary score and converts it to decimal with a sequential double-dabble, one bit per cycle.
- Tracks the session high score and drives four active-low 7-segment digits showing the final score in decimal.
- Sits beside the score counter in the top level; its outputs feed the board HEX displays after game-over.

Parameters:
- BLINK_DIV, 25000000, clk cycles per blink half-period; used only with SCORE_BLINK_EN.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- score  in  16  binary score from the score counter.
- collision  in  1  game-over indication; level signal.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when results update.
- final_bcd  out  20  five BCD digits of the captured score; [19:16] is the ten-thousands digit.
- hi_score  out  16  highest captured score since reset.
- new_high  out  1  last capture strictly exceeded the previous hi_score.
- ovf  out  1  last capture exceeded 9999; HEX shows only the low 4 digits.
- HEX0..HEX3  out  [0:6] each  active-low segments, bit 0 = segment a; HEX0 = units digit.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - State goes to IDLE.
  - busy=0, done=0, final_bcd=0, hi_score=0, new_high=0, ovf=0.
  - HEX0..3 = 7'b0000001 (shows "0000").
  - collision_d is cleared.
  - Applies mid-conversion: the conversion is aborted and no result is written.
- Edge detect: collision_d is a register holding the previous collision. A trigger is collision=1 && collision_d=0.
- State machine: IDLE, CONV, DONE, HOLD.
  - IDLE, trigger at edge k: shift register <= score; BCD accumulator <= 0; cnt <= 0; go to CONV; busy=1 from k.
  - CONV, edges k+1..k+16, one iteration per edge: add 3 to every BCD nibble >= 5, then shift {bcd, shift} left by 1. At cnt==15, go to DONE.
  - DONE, edge k+17:
    - final_bcd <= accumulator.
    - ovf <= (accumulator[19:16] != 0).
    - If captured > hi_score: hi_score <= captured and new_high <= 1; otherwise new_high <= 0. Equal scores do not update.
    - done=1 for exactly one cycle; busy=0; go to HOLD.
  - HOLD: stay while collision=1. Return to IDLE when collision=0.
- Triggers in CONV, DONE or HOLD are ignored; there is no queueing. The captured value is frozen at edge k, so later score changes have no effect.
- HEX[i] decodes final_bcd[4i+3:4i] via the decimal table:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
  - Any nibble >9 (cannot occur) shows blank, 1111111.
- HEX outputs are registered; they update at the same edge as done.
- Maximum input is 65535, giving final_bcd = 0x65535.

Optional Feature:
- Macro: SCORE_BLINK_EN.
- Defined:
  - A BLINK_DIV counter toggles a phase bit.
  - While new_high=1 and phase=1, all HEX outputs = 7'b1111111 (blank).
  - The counter and phase reset to 0 and restart when done pulses.
- Undefined: HEX is steady; BLINK_DIV is unused; no counter logic exists.

Decomposition:
- Package score_pkg contains:
  - State enum {IDLE, CONV, DONE, HOLD}.
  - Constants SEG_BLANK=7'b1111111 and SEG_ZERO=7'b0000001.
  - BCD_DIGITS=5 and CONV_BITS=16.
- One combinational sub-module, seg7_dec (4-bit decimal digit -> 7 segments), instantiated four times. The FSM and datapath stay in score_bcd_reader.

Test Plan:
- Reset, then score=1234 and a collision rise at edge k:
  - busy=1 during k..k+16; done=1 only for the cycle after edge k+17.
  - final_bcd=0x01234; ovf=0; HEX3=1001111, HEX2=0010010, HEX1=0000110, HEX0=1001100.
- Captures 50, 30, 50, 70 (collision dropped between each):
  - hi_score = 50, 50, 50, 70.
  - new_high = 1, 0, 0, 1.
- score=9999 -> ovf=0, HEX="9999". score=10000 -> final_bcd=0x10000, ovf=1, HEX="0000". score=65535 -> final_bcd=0x65535.
- resetn=0 at edge k+8 mid-conversion:
  - All outputs return to reset values; no done pulse.
  - A fresh trigger afterwards converts correctly.
- Collision toggled 0->1 at k+5 during CONV, and held high through HOLD: exactly one done pulse; final_bcd reflects the score sampled at k.
- With SCORE_BLINK_EN and BLINK_DIV=4 after a new high: HEX alternates between digits and 1111111 every 4 cycles. With score not greater than hi_score: HEX is steady.
